// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor: one full-adder cell is stepped over WIDTH cycles, LSB first,
// behind a start/done handshake. Results are committed only on the final bit.
module serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    count;

    logic ha_s;
    logic ha_c;
    logic bit_s;
    logic carry_n;
    logic last_bit;

    // Full adder as two half adders plus carry OR.
    assign ha_s     = op_a[0] ^ op_b[0];
    assign ha_c     = op_a[0] & op_b[0];
    assign bit_s    = ha_s ^ carry;
    assign carry_n  = ha_c | (ha_s & carry);
    assign last_bit = (count == CW'(WIDTH - 1));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub;
                        count <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    res   <= {bit_s, res[WIDTH-1:1]};
                    carry <= carry_n;
                    if (last_bit) begin
                        // On the MSB step, carry still holds the carry into the MSB.
                        sum   <= {bit_s, res[WIDTH-1:1]};
                        cout  <= carry_n;
                        ovf   <= carry ^ carry_n;
                        state <= DONE;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Bench for serial_addsub_ctrl: arithmetic reference model checked every cycle, plus
// directed operations with hand-computed results, timing, reset and back-to-back cases.
module tb_serial_addsub_ctrl;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic         sub   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int errors = 0;
    int checks = 0;

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .sub  (sub),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {ovf, cout, sum} from integer add/subtract.
    function automatic logic [W+1:0] predict(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
        int ux, uy, sx, sy, ur, sr;
        logic c, o;
        logic [W-1:0] r;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            ur = ux - uy;
            sr = sx - sy;
            c  = (ux >= uy);
        end else begin
            ur = ux + uy;
            sr = sx + sy;
            c  = (ur >= (1 << W));
        end
        o = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        r = W'(ur);
        return {o, c, r};
    endfunction

    // Transaction-level model: accept, W cycles of work, one done cycle.
    logic         m_active = 1'b0;
    int           m_left   = 0;
    logic         m_done   = 1'b0;
    logic [W-1:0] m_sum    = '0;
    logic         m_cout   = 1'b0;
    logic         m_ovf    = 1'b0;
    logic [W-1:0] p_sum    = '0;
    logic         p_cout   = 1'b0;
    logic         p_ovf    = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_left   <= 0;
            m_done   <= 1'b0;
            m_sum    <= '0;
            m_cout   <= 1'b0;
            m_ovf    <= 1'b0;
        end else if (m_active) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
                m_sum    <= p_sum;
                m_cout   <= p_cout;
                m_ovf    <= p_ovf;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_active <= 1'b1;
                m_left   <= W;
                {p_ovf, p_cout, p_sum} <= predict(a, b, sub);
            end
        end
    end

    always @(negedge clk) begin
        chk("model_busy", busy, m_active);
        chk("model_done", done, m_done);
        chk("model_sum",  sum,  m_sum);
        chk("model_cout", cout, m_cout);
        chk("model_ovf",  ovf,  m_ovf);
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic ts,
                          input logic [W-1:0] es, input logic ec, input logic eo,
                          input int inj, input string nm);
        int n, nb;
        @(negedge clk);
        a = ta; b = tb_b; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        nb = 0;
        while (!done && n < 20) begin
            if (busy) nb++;
            @(negedge clk);
            n++;
            start = (n == inj);
            if (n == inj) begin
                a = 8'hAA; b = 8'h55;
            end
        end
        start = 1'b0;
        chk({nm, "_latency"}, n - 1, W);
        chk({nm, "_busy_cycles"}, nb, W);
        chk({nm, "_sum"}, sum, es);
        chk({nm, "_cout"}, cout, ec);
        chk({nm, "_ovf"}, ovf, eo);
        @(negedge clk);
        chk({nm, "_done_falls"}, done, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1, d2, nd;
        logic [W-1:0] s1, s2;
        logic b10;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sum", sum, 8'h00);
        rst = 1'b0;

        run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 0, "add_35_4a");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, "add_ff_01");
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0, "add_7f_01");
        run_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 0, "sub_10_20");
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 3, "ignored_start");
        run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 0, "sub_80_01");

        // Reset in the middle of an operation, between clock edges.
        @(negedge clk);
        a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_sum", sum, 8'h00);
        chk("midrst_cout", cout, 1'b0);
        chk("midrst_ovf", ovf, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0, "post_rst");

        // Back-to-back: start held high, operands changed after each accept.
        @(negedge clk);
        a = 8'h35; b = 8'h4A; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'h10; b = 8'h20; sub = 1'b1;
        d1 = -1; d2 = -1; nd = 0; s1 = '0; s2 = '0; b10 = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            if (done) begin
                nd++;
                if (d1 < 0) begin
                    d1 = n; s1 = sum;
                end else begin
                    d2 = n; s2 = sum;
                end
            end
            if (n == 10) begin
                b10 = busy;
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b_done_count", nd, 2);
        chk("b2b_first_done", d1, 9);
        chk("b2b_second_done", d2, 18);
        chk("b2b_first_sum", s1, 8'h7F);
        chk("b2b_second_sum", s2, 8'hF0);
        chk("b2b_reentered_run", b10, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_addsub_ctrl.md
# serial_addsub_ctrl

Bit-serial adder/subtractor controller that sequences one full-adder cell (two half adders plus carry OR) over WIDTH clock cycles, LSB first. It replaces a WIDTH-bit ripple array where area matters more than latency. It sits beside the structural adder cells in the Adders and Subtractors library and presents a start/done handshake to the requesting logic.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous and active-high
- start  input  1  request; sampled on every rising edge and accepted only in IDLE or DONE
- sub  input  1  0 = a+b, 1 = a−b; captured with the operands
- a  input  WIDTH  operand A, two's complement or unsigned; captured on accept
- b  input  WIDTH  operand B; captured on accept
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when a result has been committed
- sum  output  WIDTH  result of the last completed operation
- cout  output  1  final carry out; for subtraction, 1 = no borrow
- ovf  output  1  signed overflow of the last completed operation

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE.
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0. All internal shift registers, the carry flop and the bit counter clear to 0.
- IDLE or DONE with start=1: capture opA=a and opB = sub ? ~b : b. Set carry=sub, count=0 and go to RUN.
- DONE with start=0: go to IDLE.
- IDLE with start=0: stay in IDLE.
- RUN, each cycle:
  - bit s = opA[0]^opB[0]^carry; carry' = majority(opA[0], opB[0], carry).
  - Shift opA and opB right by one. Shift s into the MSB of the result shift register.
  - Before updating carry on the bit at index WIDTH−1, save carry as c_msb (the carry into the MSB).
  - Increment count.
- When count reaches WIDTH−1 and the last bit has been processed, go to DONE. On that same edge commit:
  - sum = final result register
  - cout = carry'
  - ovf = c_msb ^ carry'
- start is ignored while in RUN. There is no queueing and no error flag.
- sum, cout and ovf change only on the commit edge. They hold stable through RUN and IDLE.
- Arithmetic is modulo 2^WIDTH. cout and ovf report the carry-out and signed overflow respectively.
- The count register is ceil(log2(WIDTH)) bits wide and never wraps past WIDTH−1.

## Timing
- Let start be sampled high at edge k (accept edge).
- Edge k: busy=1 from edge k onward.
- Edges k+1 through k+WIDTH: process bits 0 through WIDTH−1.
- Edge k+WIDTH: state becomes DONE. busy falls and done rises. sum, cout and ovf are updated on this edge.
- Edge k+WIDTH+1: done falls.
- Latency from accept to done is WIDTH cycles.
- Back-to-back operation: start held high through DONE is accepted at edge k+WIDTH+1. The new operation enters RUN and done stays high for exactly one cycle. Throughput is one result per WIDTH+1 cycles.
- Asserting rst at any time forces IDLE and all reset values immediately, without waiting for a clock edge. A partial result is discarded and done does not pulse.
- The first edge after rst deasserts may accept start.

## Test plan
- WIDTH=8, add 0x35+0x4A → done exactly 8 cycles after the accept edge; sum=0x7F, cout=0, ovf=0. busy is high for exactly 8 cycles.
- Add 0xFF+0x01 → sum=0x00, cout=1, ovf=0. Add 0x7F+0x01 → sum=0x80, cout=0, ovf=1.
- Sub 0x10−0x20 → sum=0xF0, cout=0, ovf=0. Sub 0x80−0x01 → sum=0x7F, cout=1, ovf=1.
- Start 0x01+0x01, then pulse start with a=0xAA, b=0x55 at cycle 3 of RUN → pulse is ignored; sum=0x02 and busy timing is unchanged.
- Assert rst in cycle 4 of RUN → immediately busy=0, done=0, sum=0, cout=0, ovf=0. Release rst, run 0x0F+0x01 → sum=0x10.
- Hold start high with a new operand each accept → results 0x35+0x4A and then sub 0x10−0x20 complete correctly. done pulses once per operation, 9 cycles apart.
